// File: rtl/ps_pkg.sv
// Shared definitions for the ps_* pixel-stream blocks: FSM state encoding and
// frame geometry helper.
package ps_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FINISH = 2'd2
  } ps_state_e;

  function automatic int unsigned frame_pixels(input int unsigned h_active,
                                               input int unsigned v_active);
    return h_active * v_active;
  endfunction

endpackage

// File: rtl/ps_skid2.sv
// Two-entry pixel skid buffer: absorbs the one-cycle FIFO read latency so the
// write side can stall on framebuffer backpressure without losing pixels.
module ps_skid2 #(
  parameter int DATA_WIDTH = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_flush,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [1:0]            o_occ,
  output logic [DATA_WIDTH-1:0] o_head
);

  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [1:0]            occ_q, occ_d;

  // Callers never pop when empty nor push into a full buffer without a pop.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (i_flush) begin
      occ_d = 2'd0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (occ_q == 2'd0) begin
            head_d = i_push_data;
          end else begin
            tail_d = i_push_data;
          end
          occ_d = occ_q + 2'd1;
        end
        2'b01: begin
          head_d = tail_q;
          occ_d  = occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            head_d = i_push_data;
          end else begin
            head_d = tail_q;
            tail_d = i_push_data;
          end
        end
        default: begin
          occ_d = occ_q;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign o_occ  = occ_q;
  assign o_head = head_q;

endmodule

// File: rtl/ps_fb_writer.sv
// Drains processed pixels from the obuf FIFO and writes them in raster order to
// the framebuffer write port, counting pixels and completed frames.
module ps_fb_writer
  import ps_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_enable,
  input  logic                  i_flush,
  input  logic [DATA_WIDTH-1:0] i_obuf_data,
  input  logic                  i_obuf_almostempty,
  output logic                  o_obuf_rd,
  output logic                  o_mem_wr,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  input  logic                  i_mem_ready,
  output logic                  o_frame_done,
  output logic [7:0]            o_frame_count,
  output logic                  o_busy
);

  localparam int unsigned FRAME = frame_pixels(H_ACTIVE, V_ACTIVE);
  localparam logic [ADDR_WIDTH:0]   RD_FULL   = (ADDR_WIDTH + 1)'(FRAME);
  localparam logic [ADDR_WIDTH:0]   RD_LAST   = (ADDR_WIDTH + 1)'(FRAME - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME - 1);

  ps_state_e             state_q, state_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [ADDR_WIDTH:0]   rd_count_q, rd_count_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic                  frame_done_q, frame_done_d;
  logic [7:0]            frame_count_q, frame_count_d;

  logic [1:0]            skid_occ;
  logic [DATA_WIDTH-1:0] skid_head;
  logic                  pop;
  logic                  frame_end_pop;
  logic                  at_boundary;
  logic                  rd_room;
  logic                  finish_hold;
  logic                  rd_clean;

  ps_skid2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_flush    (i_flush),
    .i_push     (rd_pend_q),
    .i_push_data(i_obuf_data),
    .i_pop      (pop),
    .o_occ      (skid_occ),
    .o_head     (skid_head)
  );

  // A read is only issued when its data is guaranteed a skid slot on arrival.
  // FINISH never starts reads of a new frame, so rd_count of 0 also holds reads.
  always_comb begin
    o_mem_wr      = (skid_occ != 2'd0);
    pop           = o_mem_wr & i_mem_ready;
    frame_end_pop = pop && (wr_addr_q == LAST_ADDR);
    at_boundary   = (rd_count_q == '0) && (wr_addr_q == '0) &&
                    (skid_occ == 2'd0) && !rd_pend_q;
    rd_clean      = (rd_count_q == '0) || (rd_count_q == RD_FULL);
    rd_room       = (({1'b0, skid_occ} + {2'b00, rd_pend_q}) < (3'd2 + {2'b00, pop}));
    finish_hold   = (state_q == ST_FINISH) && rd_clean;
    o_obuf_rd     = (state_q != ST_IDLE) && !i_obuf_almostempty && rd_room &&
                    !finish_hold && !i_flush;
  end

  always_comb begin
    state_d       = state_q;
    rd_pend_d     = o_obuf_rd;
    rd_count_d    = rd_count_q;
    wr_addr_d     = wr_addr_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;

    if (o_obuf_rd) begin
      if ((state_q == ST_ACTIVE) && (rd_count_q == RD_LAST)) begin
        rd_count_d = '0;
      end else begin
        rd_count_d = rd_count_q + 1'b1;
      end
    end

    if (pop) begin
      if (frame_end_pop) begin
        wr_addr_d     = '0;
        frame_done_d  = 1'b1;
        frame_count_d = frame_count_q + 8'd1;
      end else begin
        wr_addr_d = wr_addr_q + 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        rd_count_d = '0;
        if (i_enable) begin
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (!i_enable) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        if (i_enable) begin
          state_d = ST_ACTIVE;
          if (rd_count_q == RD_FULL) begin
            rd_count_d = '0;
          end
        end else if ((frame_end_pop && rd_clean) || at_boundary) begin
          state_d    = ST_IDLE;
          rd_count_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (i_flush) begin
      state_d       = ST_IDLE;
      rd_pend_d     = 1'b0;
      rd_count_d    = '0;
      wr_addr_d     = '0;
      frame_done_d  = 1'b0;
      frame_count_d = frame_count_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q       <= ST_IDLE;
      rd_pend_q     <= 1'b0;
      rd_count_q    <= '0;
      wr_addr_q     <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      rd_pend_q     <= rd_pend_d;
      rd_count_q    <= rd_count_d;
      wr_addr_q     <= wr_addr_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign o_mem_addr    = wr_addr_q;
  assign o_mem_data    = skid_head;
  assign o_frame_done  = frame_done_q;
  assign o_frame_count = frame_count_q;
  assign o_busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ps_fb_writer.sv
// Scoreboard bench for ps_fb_writer on a 4x2 frame: a queue-based obuf FIFO
// model feeds pixels, and every accepted write is matched against the queue.
module tb_ps_fb_writer;

  localparam int AW = 3;
  localparam int DW = 12;
  localparam logic [AW-1:0] LAST = 3'd7;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } sb_t;

  logic          i_clk = 1'b0;
  logic          i_rstn;
  logic          i_enable;
  logic          i_flush;
  logic [DW-1:0] i_obuf_data;
  logic          i_obuf_almostempty;
  logic          o_obuf_rd;
  logic          o_mem_wr;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_data;
  logic          i_mem_ready;
  logic          o_frame_done;
  logic [7:0]    o_frame_count;
  logic          o_busy;

  always #5 i_clk = ~i_clk;

  ps_fb_writer #(
    .H_ACTIVE  (4),
    .V_ACTIVE  (2),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .i_clk             (i_clk),
    .i_rstn            (i_rstn),
    .i_enable          (i_enable),
    .i_flush           (i_flush),
    .i_obuf_data       (i_obuf_data),
    .i_obuf_almostempty(i_obuf_almostempty),
    .o_obuf_rd         (o_obuf_rd),
    .o_mem_wr          (o_mem_wr),
    .o_mem_addr        (o_mem_addr),
    .o_mem_data        (o_mem_data),
    .i_mem_ready       (i_mem_ready),
    .o_frame_done      (o_frame_done),
    .o_frame_count     (o_frame_count),
    .o_busy            (o_busy)
  );

  int checks = 0;
  int passes = 0;

  sb_t           sb[$];
  logic [DW-1:0] fifo[$];
  int            ae_min = 1;
  logic [AW-1:0] exp_push_addr = '0;
  logic [7:0]    exp_fc = 8'd0;
  bit            exp_fd = 1'b0;
  bit            rd_prev = 1'b0;
  bit            stall_prev = 1'b0;
  bit            chk_occ = 1'b0;
  logic [AW-1:0] held_addr;
  logic [DW-1:0] held_data;
  bit            s_rd, s_wr;
  logic [AW-1:0] s_addr;
  logic [AW-1:0] first_addr, last_addr;
  int            cyc = 0;
  int            acc_count = 0;
  int            rd_total = 0;
  int            first_acc_cyc = 0;
  int            last_acc_cyc = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      passes++;
    end
  endtask

  task automatic checkResetOutputs(input string pfx);
    checkOutput({pfx, "_obuf_rd"}, 32'(o_obuf_rd), 0);
    checkOutput({pfx, "_mem_wr"}, 32'(o_mem_wr), 0);
    checkOutput({pfx, "_mem_addr"}, 32'(o_mem_addr), 0);
    checkOutput({pfx, "_mem_data"}, 32'(o_mem_data), 0);
    checkOutput({pfx, "_frame_done"}, 32'(o_frame_done), 0);
    checkOutput({pfx, "_frame_count"}, 32'(o_frame_count), 0);
    checkOutput({pfx, "_busy"}, 32'(o_busy), 0);
  endtask

  // One clock cycle: feed read data, settle, score outputs, advance the edge.
  task automatic applyStimulus();
    sb_t e;
    bit  acc;
    bit  fd_next;
    fd_next = 1'b0;
    if (rd_prev) begin
      checkOutput("fifo_has_data", 32'(fifo.size() > 0), 1);
      if (fifo.size() > 0) begin
        i_obuf_data = fifo.pop_front();
        e.addr = exp_push_addr;
        e.data = i_obuf_data;
        sb.push_back(e);
        exp_push_addr = (exp_push_addr == LAST) ? '0 : exp_push_addr + 1'b1;
      end
    end
    i_obuf_almostempty = (fifo.size() < ae_min);
    #1;
    checkOutput("frame_done", 32'(o_frame_done), 32'(exp_fd));
    checkOutput("frame_count", 32'(o_frame_count), 32'(exp_fc));
    if (i_flush) checkOutput("rd_during_flush", 32'(o_obuf_rd), 0);
    if (stall_prev) begin
      checkOutput("stall_wr", 32'(o_mem_wr), 1);
      checkOutput("stall_addr", 32'(o_mem_addr), 32'(held_addr));
      checkOutput("stall_data", 32'(o_mem_data), 32'(held_data));
    end
    if (chk_occ) checkOutput("occ_le2", 32'(dut.skid_occ <= 2'd2), 1);
    acc = o_mem_wr && i_mem_ready;
    if (acc) begin
      checkOutput("sb_has_entry", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("wr_addr", 32'(o_mem_addr), 32'(e.addr));
        checkOutput("wr_data", 32'(o_mem_data), 32'(e.data));
        if (!i_flush && e.addr == LAST) begin
          fd_next = 1'b1;
          exp_fc  = exp_fc + 8'd1;
        end
      end
      if (acc_count == 0) begin
        first_acc_cyc = cyc;
        first_addr    = o_mem_addr;
      end
      last_acc_cyc = cyc;
      last_addr    = o_mem_addr;
      acc_count++;
    end
    stall_prev = o_mem_wr && !i_mem_ready && !i_flush;
    held_addr  = o_mem_addr;
    held_data  = o_mem_data;
    s_rd       = o_obuf_rd;
    s_wr       = o_mem_wr;
    s_addr     = o_mem_addr;
    rd_prev    = o_obuf_rd;
    if (o_obuf_rd) rd_total++;
    if (i_flush) begin
      sb.delete();
      exp_push_addr = '0;
    end
    exp_fd = fd_next;
    cyc++;
    @(posedge i_clk);
    #1;
  endtask

  task automatic stopAndWaitIdle(input string tag);
    i_enable = 1'b0;
    for (int i = 0; i < 30 && o_busy; i++) applyStimulus();
    checkOutput({tag, "_idle"}, 32'(o_busy), 0);
  endtask

  task automatic loadFifo(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) fifo.push_back(base + DW'(i));
  endtask

  initial begin
    i_rstn             = 1'b0;
    i_enable           = 1'b0;
    i_flush            = 1'b0;
    i_mem_ready        = 1'b0;
    i_obuf_data        = '0;
    i_obuf_almostempty = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    checkResetOutputs("rst");
    i_rstn = 1'b1;

    // Full frame, no stall
    loadFifo(8, 12'h001);
    i_mem_ready = 1'b1;
    i_enable    = 1'b1;
    acc_count   = 0;
    for (int i = 0; i < 40 && acc_count < 8; i++) applyStimulus();
    checkOutput("t1_writes", 32'(acc_count), 8);
    applyStimulus();
    checkOutput("t1_frame_count", 32'(o_frame_count), 1);
    checkOutput("t1_span", 32'(last_acc_cyc - first_acc_cyc), 7);
    stopAndWaitIdle("t1");

    // Backpressure over two frames
    loadFifo(16, 12'h010);
    i_enable  = 1'b1;
    chk_occ   = 1'b1;
    acc_count = 0;
    for (int k = 0; k < 200 && acc_count < 16; k++) begin
      i_mem_ready = (k % 4 == 0) || (k % 4 == 3);
      applyStimulus();
    end
    checkOutput("t2_writes", 32'(acc_count), 16);
    i_mem_ready = 1'b1;
    applyStimulus();
    checkOutput("t2_frame_count", 32'(o_frame_count), 3);
    chk_occ = 1'b0;
    stopAndWaitIdle("t2");

    // Stop at frame end
    loadFifo(20, 12'h100);
    i_enable  = 1'b1;
    acc_count = 0;
    rd_total  = 0;
    for (int i = 0; i < 20 && acc_count < 3; i++) applyStimulus();
    i_enable = 1'b0;
    for (int i = 0; i < 60 && o_busy; i++) applyStimulus();
    checkOutput("t3_idle", 32'(o_busy), 0);
    checkOutput("t3_reads", 32'(rd_total), 8);
    checkOutput("t3_writes", 32'(acc_count), 8);
    checkOutput("t3_last_addr", 32'(last_addr), 7);
    checkOutput("t3_fifo_left", 32'(fifo.size()), 12);
    checkOutput("t3_frame_count", 32'(o_frame_count), 4);
    repeat (5) applyStimulus();
    checkOutput("t3_no_rd_after", 32'(rd_total), 8);
    fifo.delete();

    // Flush mid-frame
    loadFifo(16, 12'h200);
    i_enable = 1'b1;
    for (int i = 0; i < 30 && !(s_wr && s_addr == 3'd5 && s_rd); i++) applyStimulus();
    checkOutput("t4_reached_addr5", 32'(s_wr && s_addr == 3'd5 && s_rd), 1);
    i_flush = 1'b1;
    applyStimulus();
    i_flush = 1'b0;
    checkOutput("t4_idle_after_flush", 32'(o_busy), 0);
    checkOutput("t4_fc_kept", 32'(o_frame_count), 4);
    fifo.delete();
    loadFifo(8, 12'h280);
    acc_count = 0;
    for (int i = 0; i < 40 && acc_count < 8; i++) applyStimulus();
    checkOutput("t4_writes", 32'(acc_count), 8);
    checkOutput("t4_restart_addr", 32'(first_addr), 0);
    applyStimulus();
    checkOutput("t4_frame_count", 32'(o_frame_count), 5);
    stopAndWaitIdle("t4");

    // Almost-empty gating
    ae_min = 2;
    loadFifo(1, 12'h3A0);
    i_enable = 1'b1;
    rd_total = 0;
    repeat (5) applyStimulus();
    checkOutput("t5_no_rd_ae", 32'(rd_total), 0);
    loadFifo(8, 12'h3B0);
    applyStimulus();
    checkOutput("t5_rd_resume", 32'(s_rd), 1);
    acc_count = 0;
    for (int i = 0; i < 40 && acc_count < 8; i++) applyStimulus();
    checkOutput("t5_writes", 32'(acc_count), 8);
    applyStimulus();
    checkOutput("t5_frame_count", 32'(o_frame_count), 6);
    stopAndWaitIdle("t5");
    checkOutput("t5_fifo_left", 32'(fifo.size()), 1);
    fifo.delete();
    ae_min = 1;

    // Async reset while a write is pending
    loadFifo(8, 12'h400);
    i_mem_ready = 1'b0;
    i_enable    = 1'b1;
    for (int i = 0; i < 10 && !s_wr; i++) applyStimulus();
    checkOutput("t6_wr_pending", 32'(o_mem_wr), 1);
    i_rstn = 1'b0;
    #1;
    checkResetOutputs("t6");
    i_enable = 1'b0;
    @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
    sb.delete();
    fifo.delete();
    exp_push_addr = '0;
    exp_fc        = 8'd0;
    exp_fd        = 1'b0;
    rd_prev       = 1'b0;
    stall_prev    = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
